// File: rtl/mod_gmsk.sv
// Baseband GMSK modulator: serial bits -> upsampled NRZ -> moving-average shaping ->
// phase accumulator -> quarter-wave sine ROM -> registered I/Q at the sample rate.
module mod_gmsk #(
    parameter int SYS_CLK_FREQ    = 6_400_000,
    parameter int SAMPLE_RATE     = 800,
    parameter int SAMPLES_PER_BIT = 8,
    parameter int MA_LEN          = 4,
    parameter int AMPLITUDE       = 16000
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               bit_in,
    input  logic               bit_valid,
    output logic               bit_ready,
    output logic signed [15:0] I,
    output logic signed [15:0] Q,
    output logic               iq_valid,
    output logic [9:0]         phase,
    output logic signed [6:0]  freq,
    output logic               underrun,
    output logic               busy
);
    localparam int SAMPLE_DIV = SYS_CLK_FREQ / SAMPLE_RATE;
    localparam int CNT_W      = $clog2(SAMPLE_DIV);
    localparam int SLOT_W     = $clog2(SAMPLES_PER_BIT);
    localparam int MA_SH      = $clog2(MA_LEN);
    localparam int SUM_W      = 7 + MA_SH;
    localparam logic signed [6:0] DEV = 7'sd32;

    // state | meaning
    // IDLE  | no transmission, delay line zero, phase held
    // RUN   | shaping the current bit, loading the next one at slot 0
    // DRAIN | pushing zeros until the delay line is flushed
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q;
    logic [SLOT_W-1:0]        slot_q, slot_d;
    logic [2:0]               drain_q, drain_d;
    logic                     cur_act_q, cur_act_d, cur_bit_q, cur_bit_d;
    logic                     next_full_q, next_bit_q, rdy_en_q;
    logic signed [6:0]        line_q [MA_LEN];
    logic signed [6:0]        line_d [MA_LEN];
    logic signed [6:0]        raw, freq_q, freq_d;
    logic signed [SUM_W-1:0]  sum;
    logic [9:0]               phase_q, phase_d;
    logic                     tick_q, iq_valid_q, underrun_q;
    logic signed [15:0]       i_q, q_q;
    logic                     sample_en, bnd, load, urun, accept;

    function automatic int qtab(input logic [4:0] a);
        int v;
        case (a)
            5'd0:  v = 0;      5'd1:  v = 1568;   5'd2:  v = 3121;   5'd3:  v = 4645;
            5'd4:  v = 6123;   5'd5:  v = 7542;   5'd6:  v = 8889;   5'd7:  v = 10150;
            5'd8:  v = 11314;  5'd9:  v = 12368;  5'd10: v = 13304;  5'd11: v = 14111;
            5'd12: v = 14782;  5'd13: v = 15311;  5'd14: v = 15693;  5'd15: v = 15923;
            5'd16: v = 16000;
            default: v = 0;
        endcase
        return v;
    endfunction

    // Table is normalised to 16000; other amplitudes are rescaled with rounding.
    function automatic logic signed [15:0] rom_sin(input logic [5:0] k);
        logic [4:0] a;
        int         mag;
        a   = k[4] ? 5'd16 - {1'b0, k[3:0]} : {1'b0, k[3:0]};
        mag = (qtab(a) * AMPLITUDE + 8000) / 16000;
        return k[5] ? 16'(-mag) : 16'(mag);
    endfunction

    assign sample_en = (cnt_q == CNT_W'(SAMPLE_DIV - 1));
    assign bit_ready = start & ~next_full_q & rdy_en_q;
    assign accept    = bit_valid & bit_ready;

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        drain_d   = drain_q;
        cur_act_d = cur_act_q;
        cur_bit_d = cur_bit_q;
        bnd       = 1'b0;
        if (sample_en) begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_RUN;
                        slot_d  = '0;
                        bnd     = 1'b1;
                    end
                end
                S_RUN: begin
                    slot_d = slot_q + 1'b1;
                    if (slot_d == '0) begin
                        if (!start) begin
                            state_d   = S_DRAIN;
                            drain_d   = 3'(MA_LEN - 2);
                            cur_act_d = 1'b0;
                        end else begin
                            bnd = 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_q == '0) state_d = S_IDLE;
                    else               drain_d = drain_q - 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end
        load = bnd & next_full_q;
        urun = bnd & ~next_full_q;
        if (bnd) begin
            cur_act_d = next_full_q;
            cur_bit_d = next_bit_q;
        end
        raw = '0;
        if (state_d == S_RUN && cur_act_d) raw = cur_bit_d ? DEV : -DEV;
    end

    // Raw steps are multiples of 32, so the shift-divide is exact for MA_LEN <= 8.
    always_comb begin
        line_d[0] = raw;
        for (int k = 1; k < MA_LEN; k++) line_d[k] = line_q[k-1];
        sum = '0;
        for (int k = 0; k < MA_LEN; k++) sum = sum + SUM_W'(line_d[k]);
        freq_d  = 7'(sum >>> MA_SH);
        phase_d = phase_q + {{3{freq_d[6]}}, freq_d};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q       <= '0;
            state_q     <= S_IDLE;
            slot_q      <= '0;
            drain_q     <= '0;
            cur_act_q   <= 1'b0;
            cur_bit_q   <= 1'b0;
            next_full_q <= 1'b0;
            next_bit_q  <= 1'b0;
            rdy_en_q    <= 1'b0;
            for (int k = 0; k < MA_LEN; k++) line_q[k] <= '0;
            freq_q      <= '0;
            phase_q     <= '0;
            tick_q      <= 1'b0;
            iq_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            i_q         <= 16'(AMPLITUDE);
            q_q         <= '0;
        end else begin
            rdy_en_q   <= 1'b1;
            cnt_q      <= sample_en ? '0 : cnt_q + 1'b1;
            state_q    <= state_d;
            slot_q     <= slot_d;
            drain_q    <= drain_d;
            cur_act_q  <= cur_act_d;
            cur_bit_q  <= cur_bit_d;
            underrun_q <= urun;
            tick_q     <= sample_en;
            iq_valid_q <= tick_q;
            if (tick_q) begin
                i_q <= rom_sin(phase_q[9:4] + 6'd16);
                q_q <= rom_sin(phase_q[9:4]);
            end
            if (sample_en) begin
                for (int k = 0; k < MA_LEN; k++) line_q[k] <= line_d[k];
                freq_q  <= freq_d;
                phase_q <= phase_d;
            end
            if (load) next_full_q <= 1'b0;
            if (accept) begin
                next_full_q <= 1'b1;
                next_bit_q  <= bit_in;
            end
        end
    end

    assign I        = i_q;
    assign Q        = q_q;
    assign iq_valid = iq_valid_q;
    assign phase    = phase_q;
    assign freq     = freq_q;
    assign underrun = underrun_q;
    assign busy     = (state_q != S_IDLE);
endmodule

// File: tb/tb_mod_gmsk.sv
// Scoreboard bench for mod_gmsk: stimulus pushes one expected record per sample tick,
// a monitor pops and compares on every iq_valid.
module tb_mod_gmsk;
    logic clk = 1'b0;
    logic resetn, start, bit_in, bit_valid, bit_ready;
    logic signed [15:0] I, Q;
    logic iq_valid, underrun, busy;
    logic [9:0] phase;
    logic signed [6:0] freq;

    always #5 clk = ~clk;

    mod_gmsk #(
        .SYS_CLK_FREQ(6400), .SAMPLE_RATE(800), .SAMPLES_PER_BIT(8),
        .MA_LEN(4), .AMPLITUDE(16000)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .bit_in(bit_in),
        .bit_valid(bit_valid), .bit_ready(bit_ready), .I(I), .Q(Q),
        .iq_valid(iq_valid), .phase(phase), .freq(freq),
        .underrun(underrun), .busy(busy)
    );

    typedef struct {
        int freq; int phase; int i; int q; bit urun; bit busy; int hs_max;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    bit   src_bits[$];
    bit   pat[16];
    int   hs_cnt = 0;
    int   stall = 0;
    bit   stall_en = 1'b0;
    int   m_line[4];
    int   m_phase = 0;
    int   qt[17] = '{0, 1568, 3121, 4645, 6123, 7542, 8889, 10150, 11314,
                     12368, 13304, 14111, 14782, 15311, 15693, 15923, 16000};

    function automatic int m_sin(input int kk);
        int k;
        k = kk % 64;
        if (k <= 16) return qt[k];
        if (k <= 32) return qt[32-k];
        if (k < 48)  return -qt[k-32];
        return -qt[64-k];
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic wait_iq();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!iq_valid && n < 40);
        chk("iq_timeout", int'(iq_valid), 1);
        #2;
    endtask

    task automatic tick_step(input int raw, input bit urun_e, input bit busy_e, input int hs_max);
        exp_t e;
        int   s;
        for (int k = 3; k > 0; k--) m_line[k] = m_line[k-1];
        m_line[0] = raw;
        s = m_line[0] + m_line[1] + m_line[2] + m_line[3];
        e.freq   = s / 4;
        m_phase  = (m_phase + e.freq + 1024) % 1024;
        e.phase  = m_phase;
        e.i      = m_sin(m_phase / 16 + 16);
        e.q      = m_sin(m_phase / 16);
        e.urun   = urun_e;
        e.busy   = busy_e;
        e.hs_max = hs_max;
        sb.push_back(e);
        wait_iq();
    endtask

    task automatic run_pattern(input int nbits, input bit stalls);
        int hsb;
        int lim;
        stall_en = stalls;
        hsb = hs_cnt;
        for (int b = 0; b < nbits; b++) src_bits.push_back(pat[b]);
        start = 1'b1;
        for (int t = 0; t < nbits * 8; t++) begin
            lim = (t / 8 + 2 < nbits) ? t / 8 + 2 : nbits;
            tick_step(pat[t/8] ? 32 : -32, 1'b0, 1'b1, hsb + lim);
        end
        chk("hs_count", hs_cnt - hsb, nbits);
        stall_en = 1'b0;
    endtask

    task automatic drain_ticks();
        for (int k = 0; k < 3; k++) tick_step(0, 1'b0, 1'b1, -1);
        tick_step(0, 1'b0, 1'b0, -1);
    endtask

    // Source: presents queued bits, optional short stalls after each handshake.
    initial begin
        bit fire;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        forever begin
            @(negedge clk);
            fire = bit_valid && bit_ready;
            @(posedge clk);
            #1;
            if (fire && src_bits.size() > 0) begin
                void'(src_bits.pop_front());
                hs_cnt++;
                if (stall_en) stall = $urandom_range(0, 2);
            end
            if (stall > 0) begin
                bit_valid = 1'b0;
                stall--;
            end else if (src_bits.size() > 0) begin
                bit_valid = 1'b1;
                bit_in    = src_bits[0];
            end else begin
                bit_valid = 1'b0;
            end
        end
    end

    // Monitor
    initial begin
        int  cyc;
        int  last_iq;
        bit  urun_seen;
        cyc = 0;
        last_iq = -1;
        urun_seen = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!resetn) begin
                last_iq   = -1;
                urun_seen = 1'b0;
            end else begin
                if (underrun) urun_seen = 1'b1;
                if (iq_valid) begin
                    if (last_iq >= 0) chk("iq_period", cyc - last_iq, 8);
                    last_iq = cyc;
                    if (sb.size() > 0) begin
                        mon_e = sb.pop_front();
                        chk("freq", int'(freq), mon_e.freq);
                        chk("phase", int'(phase), mon_e.phase);
                        chk("I", int'(I), mon_e.i);
                        chk("Q", int'(Q), mon_e.q);
                        chk("underrun", int'(urun_seen), int'(mon_e.urun));
                        chk("busy", int'(busy), int'(mon_e.busy));
                        if (mon_e.hs_max >= 0) begin
                            checks++;
                            if (hs_cnt > mon_e.hs_max) begin
                                errors++;
                                $display("FAIL hs_ahead: handshakes %0d exceed limit %0d", hs_cnt, mon_e.hs_max);
                            end
                        end
                    end
                    urun_seen = 1'b0;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 4; k++) m_line[k] = 0;
        resetn = 1'b0;
        start  = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_I", int'(I), 16000);
        chk("rst_Q", int'(Q), 0);
        chk("rst_phase", int'(phase), 0);
        chk("rst_freq", int'(freq), 0);
        chk("rst_iq_valid", int'(iq_valid), 0);
        chk("rst_underrun", int'(underrun), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_bit_ready", int'(bit_ready), 0);
        start = 1'b0;
        @(negedge clk);
        #2;
        resetn = 1'b1;

        // Test 1: idle output
        wait_iq();
        repeat (12) tick_step(0, 1'b0, 1'b0, -1);

        // Test 2: four ones
        pat[0] = 1; pat[1] = 1; pat[2] = 1; pat[3] = 1;
        run_pattern(4, 1'b0);
        chk("t2_phase976", int'(phase), 976);
        start = 1'b0;
        drain_ticks();
        chk("t2_phase_end", int'(phase), 0);

        // Test 3: 1,0 then drain
        pat[0] = 1; pat[1] = 0;
        run_pattern(2, 1'b0);
        start = 1'b0;
        drain_ticks();
        chk("t3_phase", int'(phase), 0);
        chk("t3_freq", int'(freq), 0);
        chk("t3_busy", int'(busy), 0);

        // Test 4: single bit then underrun
        pat[0] = 1;
        run_pattern(1, 1'b0);
        tick_step(0, 1'b1, 1'b1, -1);
        repeat (3) tick_step(0, 1'b0, 1'b1, -1);
        chk("t4_phase256", int'(phase), 256);
        chk("t4_freq0", int'(freq), 0);
        repeat (4) tick_step(0, 1'b0, 1'b1, -1);
        start = 1'b0;
        drain_ticks();
        chk("t4_phase_end", int'(phase), 256);

        // Test 5: source stalls, buffer back-pressure
        pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
        pat[4] = 1; pat[5] = 0; pat[6] = 1; pat[7] = 0;
        run_pattern(8, 1'b1);
        start = 1'b0;
        drain_ticks();
        chk("t5_phase_end", int'(phase), 256);

        // Test 6: reset mid-bit
        src_bits.push_back(1'b1);
        src_bits.push_back(1'b1);
        start = 1'b1;
        repeat (5) tick_step(32, 1'b0, 1'b1, -1);
        resetn = 1'b0;
        #1;
        chk("t6_I", int'(I), 16000);
        chk("t6_Q", int'(Q), 0);
        chk("t6_phase", int'(phase), 0);
        chk("t6_freq", int'(freq), 0);
        chk("t6_iq_valid", int'(iq_valid), 0);
        chk("t6_underrun", int'(underrun), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_bit_ready", int'(bit_ready), 0);
        start = 1'b0;
        src_bits.delete();
        for (int k = 0; k < 4; k++) m_line[k] = 0;
        m_phase = 0;
        repeat (2) @(negedge clk);
        #2;
        resetn = 1'b1;
        wait_iq();
        pat[0] = 0;
        run_pattern(1, 1'b0);
        start = 1'b0;
        drain_ticks();
        chk("t6_phase_end", int'(phase), 768);
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
